// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control sequencer for an ARM-style core.
// Accepts one instruction at a time and steps it through decode, execute,
// multiply, memory, block-transfer, branch, write-back and retire states.
// Every strobe is registered except undef. undef depends on cond_pass, and
// cond_pass is only sampled during DECODE.
module instr_sequencer #(
    parameter int MUL_CYCLES  = 2,
    parameter int MULL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] opcode,
    input  logic [3:0]  dec,
    input  logic        cond_pass,
    input  logic        mem_ready,
    output logic        instr_ready,
    output logic        alu_en,
    output logic        mul_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  blk_idx,
    output logic        reg_wr_en,
    output logic        link_wr,
    output logic        pc_load,
    output logic        undef,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        MUL    = 4'd3,
        MEM    = 4'd4,
        BLOCK  = 4'd5,
        BRANCH = 4'd6,
        WB     = 4'd7,
        DONE   = 4'd8
    } state_t;

    state_t      state;
    logic [31:0] op_q;
    logic [3:0]  dec_q;
    logic [7:0]  cnt;
    logic [15:0] mask;
    logic        swap_wr;
    logic [15:0] mask_cleared;

    // Index of the lowest pending register in a block-transfer list.
    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Classes 0 and 12-15 have no defined behaviour.
    function automatic logic is_undef_class(input logic [3:0] d);
        return (d == 4'd0) || (d >= 4'd12);
    endfunction

    // Pending mask after the current lowest transfer completes.
    always_comb begin
        mask_cleared = mask & ~(16'h0001 << lowest_set(mask));
    end

    // Trap is raised during the decode cycle itself when the class is unusable.
    always_comb begin
        undef = (state == DECODE) && cond_pass && is_undef_class(dec_q);
    end

    // Sequencer state, captured instruction and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= 32'd0;
            dec_q       <= 4'd0;
            cnt         <= 8'd0;
            mask        <= 16'd0;
            swap_wr     <= 1'b0;
            instr_ready <= 1'b1;
            alu_en      <= 1'b0;
            mul_en      <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            blk_idx     <= 4'd0;
            reg_wr_en   <= 1'b0;
            link_wr     <= 1'b0;
            pc_load     <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Strobes default low; each transition raises what the next state needs.
            instr_ready <= 1'b0;
            alu_en      <= 1'b0;
            mul_en      <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            blk_idx     <= 4'd0;
            reg_wr_en   <= 1'b0;
            link_wr     <= 1'b0;
            pc_load     <= 1'b0;
            done        <= 1'b0;

            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_q  <= opcode;
                        dec_q <= dec;
                        state <= DECODE;
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end

                DECODE: begin
                    if (!cond_pass) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        case (dec_q)
                            4'd7, 4'd11: begin
                                state  <= EXEC;
                                alu_en <= 1'b1;
                            end
                            4'd1: begin
                                state  <= MUL;
                                mul_en <= 1'b1;
                                cnt    <= 8'(MUL_CYCLES - 1);
                            end
                            4'd2: begin
                                state  <= MUL;
                                mul_en <= 1'b1;
                                cnt    <= 8'(MULL_CYCLES - 1);
                            end
                            4'd3: begin
                                // Swap always reads first.
                                state   <= MEM;
                                mem_req <= 1'b1;
                                mem_we  <= 1'b0;
                                swap_wr <= 1'b0;
                            end
                            4'd4, 4'd5, 4'd6, 4'd8: begin
                                state   <= MEM;
                                mem_req <= 1'b1;
                                mem_we  <= ~op_q[20];
                                swap_wr <= 1'b0;
                            end
                            4'd9: begin
                                state <= BLOCK;
                                mask  <= op_q[15:0];
                                if (op_q[15:0] != 16'd0) begin
                                    mem_req <= 1'b1;
                                    mem_we  <= ~op_q[20];
                                    blk_idx <= lowest_set(op_q[15:0]);
                                end
                            end
                            4'd10: begin
                                state     <= BRANCH;
                                pc_load   <= 1'b1;
                                reg_wr_en <= op_q[24];
                                link_wr   <= op_q[24];
                            end
                            default: begin
                                // Undefined class: trap already signalled, no retire.
                                state       <= IDLE;
                                instr_ready <= 1'b1;
                            end
                        endcase
                    end
                end

                EXEC: begin
                    state     <= WB;
                    reg_wr_en <= 1'b1;
                end

                MUL: begin
                    if (cnt == 8'd0) begin
                        state     <= WB;
                        reg_wr_en <= 1'b1;
                    end else begin
                        cnt    <= cnt - 8'd1;
                        mul_en <= 1'b1;
                    end
                end

                MEM: begin
                    if (mem_ready) begin
                        if (dec_q == 4'd3) begin
                            if (!swap_wr) begin
                                // Read half of the swap done; issue the write.
                                swap_wr <= 1'b1;
                                mem_req <= 1'b1;
                                mem_we  <= 1'b1;
                            end else begin
                                state     <= WB;
                                reg_wr_en <= 1'b1;
                            end
                        end else if (op_q[20]) begin
                            state     <= WB;
                            reg_wr_en <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        mem_req <= 1'b1;
                        mem_we  <= mem_we;
                    end
                end

                BLOCK: begin
                    if (mask == 16'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (mem_ready) begin
                        mask <= mask_cleared;
                        if (mask_cleared == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            mem_req <= 1'b1;
                            mem_we  <= ~op_q[20];
                            blk_idx <= lowest_set(mask_cleared);
                        end
                    end else begin
                        mem_req <= 1'b1;
                        mem_we  <= ~op_q[20];
                        blk_idx <= lowest_set(mask);
                    end
                end

                BRANCH: begin
                    state <= DONE;
                    done  <= 1'b1;
                end

                WB: begin
                    state <= DONE;
                    done  <= 1'b1;
                end

                DONE: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end

                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
